// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S playback serializer.
//   FRAME_SLOTS : bit-clock periods per stereo frame (left + right channel)
//   CH_BITS     : bits per channel sample
//   state_t     : serializer run state (IDLE / RUN)
//   satInc16    : 16-bit increment that sticks at all-ones
package i2s_pkg;

  localparam int FRAME_SLOTS = 64;
  localparam int CH_BITS     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider for the I2S serializer.
// Produces a 50% duty bit clock with BCLK_DIV clk cycles per half-period,
// plus single-cycle strobes marking the clk cycle whose rising edge will
// make the bit clock rise or fall.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   run_i      : 1 = divider counts; 0 = divider held at start (bclk low)
//   bclk_o     : registered bit clock
//   rise_o     : next clk edge takes bclk 0 -> 1
//   fall_o     : next clk edge takes bclk 1 -> 0
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             halfEnd;

  // The last clk cycle of each bclk half-period; the toggle happens at its end.
  assign halfEnd = run_i && (cnt_q == CNT_LAST);

  // While stopped, the divider is parked at the start of a low half-period so
  // that the first slot after a start always begins with bclk low.
  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (halfEnd) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign rise_o = halfEnd && !bclk_q;
  assign fall_o = halfEnd && bclk_q;

endmodule

// File: rtl/i2s_playback_serializer.sv
// I2S playback serializer: pops stereo words from a show-ahead FIFO and
// shifts them out MSB-first in standard I2S framing (data one slot behind
// the word select), 64 bit-clock slots per frame with no gaps.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   enable          : run request, sampled only at frame boundaries
//   fifo_data       : [31:0] left sample, [63:32] right sample
//   fifo_empty      : FIFO has no word available
//   fifo_read       : pop strobe, only in a frame-load cycle
//   i2s_bclk        : bit clock
//   i2s_lrclk       : word select, 0 = left, 1 = right
//   i2s_data        : serial data
//   underrun        : one-cycle pulse when a frame load finds the FIFO empty
//   underrun_count  : saturating count of starved frames
module i2s_playback_serializer
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_read,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  localparam int WORD_W = 2 * CH_BITS;
  localparam int SLOT_W = $clog2(FRAME_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(FRAME_SLOTS - 1);
  localparam logic [SLOT_W-1:0] RIGHT_SLOT = SLOT_W'(CH_BITS);

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic                lrclk_q, lrclk_d;
  logic                data_q, data_d;
  logic [15:0]         underrunCount_q, underrunCount_d;

  logic bclkOut;
  logic bclkFall;
  logic unusedBclkRise;
  logic frameEnd;
  logic frameLoad;

  // Every output transition is tied to a bclk falling edge, so the rising
  // strobe has no consumer here.
  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk    (clk),
    .reset  (reset),
    .run_i  (state_q == RUN),
    .bclk_o (bclkOut),
    .rise_o (unusedBclkRise),
    .fall_o (bclkFall)
  );

  // End of slot 63 is the only point where enable is looked at while running.
  assign frameEnd  = (state_q == RUN) && bclkFall && (slot_q == LAST_SLOT);
  assign frameLoad = !reset && enable && ((state_q == IDLE) || frameEnd);

  // Shift register layout is {left, right} so a plain left shift walks left
  // bits 31..0 then right bits 31..0. Data is taken from the MSB one slot
  // before it is shifted away, which yields the one-slot I2S lag; the right
  // LSB therefore lands in slot 0 of the following frame. Clearing the shift
  // register on entry to IDLE makes that slot read 0 after a stop.
  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    shift_d         = shift_q;
    lrclk_d         = lrclk_q;
    data_d          = data_q;
    underrunCount_d = underrunCount_q;
    fifo_read       = 1'b0;
    underrun        = 1'b0;

    if (frameLoad) begin
      state_d = RUN;
      slot_d  = '0;
      lrclk_d = 1'b0;
      data_d  = shift_q[WORD_W-1];
      if (fifo_empty) begin
        shift_d         = '0;
        underrun        = 1'b1;
        underrunCount_d = satInc16(underrunCount_q);
      end else begin
        shift_d   = {fifo_data[CH_BITS-1:0], fifo_data[WORD_W-1:CH_BITS]};
        fifo_read = 1'b1;
      end
    end else if (frameEnd) begin
      state_d = IDLE;
      slot_d  = '0;
      shift_d = '0;
      lrclk_d = 1'b0;
      data_d  = 1'b0;
    end else if ((state_q == RUN) && bclkFall) begin
      slot_d  = slot_q + 1'b1;
      lrclk_d = (slot_d >= RIGHT_SLOT);
      data_d  = shift_q[WORD_W-1];
      shift_d = {shift_q[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      slot_q          <= '0;
      shift_q         <= '0;
      lrclk_q         <= 1'b0;
      data_q          <= 1'b0;
      underrunCount_q <= '0;
    end else begin
      state_q         <= state_d;
      slot_q          <= slot_d;
      shift_q         <= shift_d;
      lrclk_q         <= lrclk_d;
      data_q          <= data_d;
      underrunCount_q <= underrunCount_d;
    end
  end

  assign i2s_bclk       = bclkOut;
  assign i2s_lrclk      = lrclk_q;
  assign i2s_data       = data_q;
  assign underrun_count = underrunCount_q;

endmodule

// File: tb/tb_i2s_playback_serializer.sv
// Self-checking bench for i2s_playback_serializer.
// Stimulus pushes the expected slot bits and frame-load events into queues;
// monitors pop and compare whenever the DUT shows a bclk rise or a load
// strobe. The expected stream is built from the I2S framing rules directly.
module tb_i2s_playback_serializer;

  localparam int DIV       = 2;
  localparam int FRAME_CYC = 128 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_data;
  logic        underrun;
  logic [15:0] underrun_count;

  always #5 clk = ~clk;

  i2s_playback_serializer #(
    .BCLK_DIV (DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_read      (fifo_read),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_data       (i2s_data),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  typedef struct {
    bit lr;
    bit data;
    bit spacing;
    int slot;
  } slotExp_t;

  typedef struct {
    int          cyc;
    bit          rd;
    bit          und;
    logic [15:0] cnt;
  } loadExp_t;

  slotExp_t slotQ[$];
  loadExp_t loadQ[$];

  int checks    = 0;
  int failures  = 0;
  int cycle     = 0;
  int modelCount = 0;
  bit prevRight0 = 1'b0;
  bit prevBclk   = 1'b0;
  int lastRise   = -1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Slot s of a frame: slot 0 carries the previous right LSB, slots 1..32 the
  // left sample MSB-first, slots 33..63 the right sample bits 31..1.
  function automatic bit expectedBit(input logic [31:0] l, input logic [31:0] r,
                                     input bit p, input int s);
    if (s == 0) return p;
    else if (s <= 32) return l[32 - s];
    else return r[64 - s];
  endfunction

  task automatic pushFrame(input bit empty, input logic [63:0] word,
                           input int loadCyc, input bit firstOfRun);
    logic [31:0] l;
    logic [31:0] r;
    loadExp_t    e;
    slotExp_t    x;
    l = empty ? 32'd0 : word[31:0];
    r = empty ? 32'd0 : word[63:32];
    e.cyc = loadCyc;
    e.rd  = !empty;
    e.und = empty;
    e.cnt = 16'(modelCount);
    loadQ.push_back(e);
    if (empty && modelCount < 65535) modelCount++;
    for (int s = 0; s < 64; s++) begin
      x.lr      = (s >= 32);
      x.data    = expectedBit(l, r, prevRight0, s);
      x.spacing = !(s == 0 && firstOfRun);
      x.slot    = s;
      slotQ.push_back(x);
    end
    prevRight0 = r[0];
  endtask

  task automatic applyStimulus(input bit empty, input logic [63:0] word);
    fifo_empty = empty;
    fifo_data  = word;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] expCount);
    check({tag, ".bclk"},     i2s_bclk,       0);
    check({tag, ".lrclk"},    i2s_lrclk,      0);
    check({tag, ".data"},     i2s_data,       0);
    check({tag, ".fifoRead"}, fifo_read,      0);
    check({tag, ".underrun"}, underrun,       0);
    check({tag, ".count"},    underrun_count, expCount);
  endtask

  // Starts from IDLE (releasing reset if held) and plays n frames; enable may
  // wobble between slots 20 and 40 of non-final frames and drops at slot 20 of
  // the final frame, so the run ends in IDLE.
  task automatic runFrames(input int n, input bit firstEmpty, input logic [63:0] firstWord,
                           input int emptyPct, input bit glitch);
    int          loadCyc;
    bit          curEmpty;
    logic [63:0] curWord;
    bit          last;
    prevRight0 = 1'b0;
    curEmpty   = firstEmpty;
    curWord    = firstWord;
    applyStimulus(curEmpty, curWord);
    reset   = 1'b0;
    enable  = 1'b1;
    loadCyc = cycle;
    for (int k = 0; k < n; k++) begin
      last = (k == n - 1);
      pushFrame(curEmpty, curWord, loadCyc, k == 0);
      repeat (41 * DIV) @(posedge clk);
      #1;
      if (last) enable = 1'b0;
      else if (glitch) enable = 1'($urandom_range(0, 1));
      curEmpty = ($urandom_range(0, 99) < emptyPct);
      curWord  = {$urandom, $urandom};
      applyStimulus(curEmpty, curWord);
      repeat (40 * DIV) @(posedge clk);
      #1;
      if (!last) enable = 1'b1;
      repeat (47 * DIV) @(posedge clk);
      #1;
      loadCyc += FRAME_CYC;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleAfterRun", 16'(modelCount));
  endtask

  // Load-event monitor and slot monitor, sampling on the falling clk edge.
  always @(negedge clk) begin : monitor
    loadExp_t le;
    slotExp_t se;
    if (reset) begin
      prevBclk = 1'b0;
      lastRise = -1;
    end else begin
      if (fifo_read || underrun) begin
        if (loadQ.size() == 0) begin
          check("unexpectedLoad", {fifo_read, underrun}, 2'b00);
        end else begin
          le = loadQ.pop_front();
          check("loadCycle",    cycle,          le.cyc);
          check("loadFifoRead", fifo_read,      le.rd);
          check("loadUnderrun", underrun,       le.und);
          check("loadCount",    underrun_count, le.cnt);
        end
      end
      if (i2s_bclk && !prevBclk) begin
        if (slotQ.size() == 0) begin
          check("unexpectedBclkRise", 1, 0);
        end else begin
          se = slotQ.pop_front();
          check($sformatf("slot%0d.lrclk", se.slot), i2s_lrclk, se.lr);
          check($sformatf("slot%0d.data", se.slot),  i2s_data,  se.data);
          if (se.spacing && lastRise >= 0)
            check("bclkPeriod", cycle - lastRise, 2 * DIV);
        end
        lastRise = cycle;
      end else if (!i2s_bclk && prevBclk && lastRise >= 0) begin
        check("bclkHighTime", cycle - lastRise, DIV);
      end
      prevBclk = i2s_bclk;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with enable high and a word waiting: nothing may move.
    reset  = 1'b1;
    enable = 1'b1;
    applyStimulus(1'b0, {$urandom, $urandom});
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("inReset", 16'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] directed word then empty FIFO");
    runFrames(2, 1'b0, 64'h7FFF_FFFE_8000_0001, 100, 1'b0);

    $display("[TB] four continuous frames");
    runFrames(4, 1'b0, {$urandom, $urandom}, 0, 1'b0);

    $display("[TB] three starved frames from reset");
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    modelCount = 0;
    runFrames(3, 1'b1, {$urandom, $urandom}, 100, 1'b0);
    check("countAfter3", underrun_count, 16'd3);

    $display("[TB] underrun count saturation");
    force dut.underrunCount_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.underrunCount_q;
    modelCount = 16'hFFFE;
    runFrames(3, 1'b1, {$urandom, $urandom}, 100, 1'b0);
    check("countSaturated", underrun_count, 16'hFFFF);

    $display("[TB] randomized runs with enable glitches");
    for (int r = 0; r < 2; r++)
      runFrames($urandom_range(2, 4), 1'($urandom_range(0, 1)), {$urandom, $urandom}, 30, 1'b1);

    $display("[TB] reset at slot 40");
    prevRight0 = 1'b0;
    applyStimulus(1'b0, {$urandom, $urandom});
    enable = 1'b1;
    pushFrame(1'b0, fifo_data, cycle, 1'b1);
    repeat (81 * DIV) @(posedge clk);
    #1;
    reset = 1'b1;
    slotQ.delete();
    loadQ.delete();
    modelCount = 0;
    @(posedge clk);
    #1;
    checkOutput("midFrameReset", 16'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetHeld", 16'd0);
    runFrames(2, 1'b0, {$urandom, $urandom}, 0, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("slotQueueDrained", slotQ.size(), 0);
    check("loadQueueDrained", loadQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
